// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: requester IDs,
// FSM state encoding and default bus widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_STACK = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport drives requests and the memory response.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [3*DATA_W-1:0] wdata;
    logic [2:0]          done;
    logic                err;
    logic [DATA_W-1:0]   rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
    logic [1:0]          gnt_id;

    modport slave (
        input  req, we, addr, wdata, mem_ready, mem_rdata,
        output done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, gnt_id
    );

    modport master (
        output req, we, addr, wdata, mem_ready, mem_rdata,
        input  done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, gnt_id
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection: stack > data > fetch, unless fetch is being
// forced after too many lost arbitrations.
module mem_port_arbiter_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic       force_fetch_i,
    output req_id_e    winner_o,
    output logic       valid_o
);
    always_comb begin
        valid_o  = |req_i;
        winner_o = REQ_FETCH;
        if (force_fetch_i && req_i[0]) begin
            winner_o = REQ_FETCH;
        end else if (req_i[2]) begin
            winner_o = REQ_STACK;
        end else if (req_i[1]) begin
            winner_o = REQ_DATA;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch/data/stack requesters: serialises
// accesses, prevents fetch starvation and aborts accesses that never complete.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [3:0] STARVE_C  = 4'(STARVE_LIMIT);

    arb_state_e        state_q;
    logic [1:0]        gnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [2:0]        done_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic [7:0]        timer_q;
    logic [3:0]        starve_q;

    req_id_e           winner;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        starve_d;
    logic [2:0]        done_d;

    mem_port_arbiter_pick u_pick (
        .req_i         (bus.req),
        .force_fetch_i (starve_q == STARVE_C),
        .winner_o      (winner),
        .valid_o       (pick_valid)
    );

    always_comb begin
        sel_we    = bus.we[0];
        sel_addr  = bus.addr[ADDR_W-1:0];
        sel_wdata = bus.wdata[DATA_W-1:0];
        case (winner)
            REQ_DATA: begin
                sel_we    = bus.we[1];
                sel_addr  = bus.addr[2*ADDR_W-1:ADDR_W];
                sel_wdata = bus.wdata[2*DATA_W-1:DATA_W];
            end
            REQ_STACK: begin
                sel_we    = bus.we[2];
                sel_addr  = bus.addr[3*ADDR_W-1:2*ADDR_W];
                sel_wdata = bus.wdata[3*DATA_W-1:2*DATA_W];
            end
            default: ;
        endcase
    end

    // Fetch only counts as starved when it was actually asking and lost.
    always_comb begin
        starve_d = starve_q;
        if (winner == REQ_FETCH) begin
            starve_d = '0;
        end else if (bus.req[0] && (starve_q != STARVE_C)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign done_d = 3'b001 << gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
            starve_q    <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q       <= winner;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        busy_q      <= 1'b1;
                        timer_q     <= 8'd1;
                        starve_q    <= starve_d;
                        state_q     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    // A ready in the timeout cycle still completes normally.
                    if (bus.mem_ready) begin
                        rdata_q   <= mem_we_q ? '0 : bus.mem_rdata;
                        err_q     <= 1'b0;
                        mem_req_q <= 1'b0;
                        done_q    <= done_d;
                        state_q   <= ARB_RESP;
                    end else if (timer_q == TIMEOUT_C) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        done_q    <= done_d;
                        state_q   <= ARB_RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                ARB_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.gnt_id    = gnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: requesters and memory are modelled at transaction level;
// expected responses are queued at arbitration time and checked on done.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SL = 4;
    localparam int TO = 15;

    typedef struct {
        int          id;
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   lat_q[$];
    int   done_order[$];

    logic [15:0] shadow [64];
    logic [15:0] mem [64];

    bit [2:0]    pending = '0;
    logic        p_we [3];
    logic [15:0] p_addr [3];
    logic [15:0] p_wdata [3];
    int          issue_cyc [3];
    bit          idle = 1'b0;
    bit          gap = 1'b0;
    int          starve = 0;
    bit          rand_en = 1'b0;
    bit [2:0]    force_mask = '0;
    bit [2:0]    renew_mask = '0;
    logic        f_we [3];
    logic [15:0] f_addr [3];
    logic [15:0] f_wdata [3];
    int          force_lat = 0;

    logic [15:0] last_rdata [3];
    logic        last_err [3];
    int          last_done_cyc [3];
    int          n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'((i * 40503) ^ 16'h5a5a);
    endfunction

    function automatic int model_winner(input bit [2:0] p, input int s);
        if (s == SL && p[0]) return 0;
        if (p[2]) return 2;
        if (p[1]) return 1;
        return 0;
    endfunction

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return 1 + (r % 3);
        if (r == 7) return 4;
        if (r == 8) return TO;
        return TO + 1;
    endfunction

    task automatic issue(input int i);
        pending[i]   = 1'b1;
        issue_cyc[i] = cyc;
        if (force_mask[i]) begin
            p_we[i]       = f_we[i];
            p_addr[i]     = f_addr[i];
            p_wdata[i]    = f_wdata[i];
            force_mask[i] = 1'b0;
        end else begin
            p_we[i]    = 1'($urandom_range(0, 1));
            p_addr[i]  = 16'($urandom);
            p_wdata[i] = 16'($urandom);
        end
    endtask

    task automatic predict();
        int   w;
        int   lat;
        exp_t e;
        acc_t a;
        w = model_winner(pending, starve);
        if (w == 0) starve = 0;
        else if (pending[0] && starve < SL) starve++;
        lat = (force_lat > 0) ? force_lat : rand_lat();
        a.we = p_we[w]; a.addr = p_addr[w]; a.wdata = p_wdata[w];
        e.id  = w;
        e.err = (lat > TO);
        e.rdata = (e.err || p_we[w]) ? 16'h0 : shadow[p_addr[w][5:0]];
        e.cyc = cyc + ((lat > TO) ? TO : lat) + 1;
        if (!e.err && p_we[w]) shadow[p_addr[w][5:0]] = p_wdata[w];
        lat_q.push_back(lat);
        acc_q.push_back(a);
        exp_q.push_back(e);
        idle = 1'b0;
    endtask

    // One requester-side cycle, called at the falling edge.
    task automatic step();
        bit [2:0] d;
        d = bus.done;
        if (gap) begin idle = 1'b1; gap = 1'b0; end
        if (d != 3'b000) begin pending &= ~d; gap = 1'b1; end
        for (int i = 0; i < 3; i++) begin
            if (!pending[i] && (force_mask[i] || renew_mask[i] ||
                (rand_en && $urandom_range(0, 99) < 30))) issue(i);
        end
        bus.req   = pending;
        bus.we    = {p_we[2], p_we[1], p_we[0]};
        bus.addr  = {p_addr[2], p_addr[1], p_addr[0]};
        bus.wdata = {p_wdata[2], p_wdata[1], p_wdata[0]};
        if (idle && pending != 3'b000) predict();
    endtask

    task automatic run_quiet(input string name, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk); step(); n++;
        end while ((pending != 3'b000 || exp_q.size() != 0) && n < max_cyc);
        if (pending != 3'b000 || exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: pending=%b outstanding=%0d after %0d cycles", name, pending, exp_q.size(), n);
        end
        repeat (2) begin @(negedge clk); step(); end
    endtask

    // Response monitor
    exp_t mon_e;
    int   mon_id;
    always @(negedge clk) begin
        if (!rst && bus.done != 3'b000) begin
            mon_id = bus.done[2] ? 2 : (bus.done[1] ? 1 : 0);
            done_order.push_back(mon_id);
            last_rdata[mon_id]    = bus.rdata;
            last_err[mon_id]      = bus.err;
            last_done_cyc[mon_id] = cyc;
            n_done++;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: done=%b with nothing outstanding (cycle %0d)", bus.done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_onehot", 32'(bus.done), 32'd1 << mon_e.id);
                check("gnt_id", 32'(bus.gnt_id), mon_e.id);
                check("rdata", 32'(bus.rdata), 32'(mon_e.rdata));
                check("err", 32'(bus.err), 32'(mon_e.err));
                check("done_cycle", cyc, mon_e.cyc);
                check("busy_in_resp", 32'(bus.busy), 32'd1);
            end
        end
    end

    // Memory model: latency for each access is chosen when it is predicted.
    bit   m_active = 1'b0;
    bit   m_init = 1'b0;
    int   m_cnt = 0;
    int   m_lat = 0;
    acc_t m_a;
    always @(negedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < 64; i++) mem[i] = init_val(i);
            m_init = 1'b1;
        end
        if (!rst && bus.mem_req) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_cnt = 0;
                if (lat_q.size() == 0 || acc_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_mem_req: addr=0x%0h (cycle %0d)", bus.mem_addr, cyc);
                    m_lat = 1;
                end else begin
                    m_lat = lat_q.pop_front();
                    m_a = acc_q.pop_front();
                    check("mem_we", 32'(bus.mem_we), 32'(m_a.we));
                    check("mem_addr", 32'(bus.mem_addr), 32'(m_a.addr));
                    if (m_a.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(m_a.wdata));
                end
            end
            m_cnt++;
            if (m_cnt == m_lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr[5:0]];
                if (bus.mem_we) mem[bus.mem_addr[5:0]] = bus.mem_wdata;
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 16'($urandom);
            end
        end else begin
            m_active = 1'b0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved_done;
        for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
        for (int i = 0; i < 3; i++) begin
            p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
            f_we[i] = 1'b0; f_addr[i] = '0; f_wdata[i] = '0;
        end
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err_rdata", {15'(0), bus.err, bus.rdata}, 0);
        rst = 1'b0;
        idle = 1'b1;

        // Single fetch read, 2-cycle memory latency
        force_mask = 3'b001; f_we[0] = 1'b0; f_addr[0] = 16'h0010; force_lat = 2;
        run_quiet("fetch_read", 50);
        check("fetch_rdata", 32'(last_rdata[0]), 32'hBEEF);
        check("fetch_req_to_done", last_done_cyc[0] - issue_cyc[0] + 1, 4);

        // All three at once
        done_order.delete();
        f_we[0] = 1'b0; f_we[1] = 1'b0; f_we[2] = 1'b0;
        force_mask = 3'b111; force_lat = 1;
        run_quiet("all_three", 60);
        check("order_len", done_order.size(), 3);
        if (done_order.size() == 3) begin
            check("order_first_stack", done_order[0], 2);
            check("order_second_data", done_order[1], 1);
            check("order_third_fetch", done_order[2], 0);
        end

        // Fetch starvation: data re-requests every time it is served
        done_order.delete();
        force_mask = 3'b011; renew_mask = 3'b010; force_lat = 1;
        n = 0;
        do begin @(negedge clk); step(); n++; end while (pending[0] && n < 100);
        renew_mask = '0;
        run_quiet("starve", 60);
        check("starve_fetch_on_5th", (done_order.size() > 4) ? done_order[4] : -1, 0);
        for (int i = 0; i < 4; i++)
            check("starve_data_first4", (done_order.size() > i) ? done_order[i] : -1, 1);
        done_order.delete();
        force_mask = 3'b011;
        run_quiet("starve_cleared", 60);
        check("after_starve_data_first", (done_order.size() > 0) ? done_order[0] : -1, 1);

        // Data write that never completes
        force_mask = 3'b010; f_we[1] = 1'b1; f_addr[1] = 16'h0200; f_wdata[1] = 16'h1234;
        force_lat = TO + 1;
        run_quiet("timeout", 60);
        check("timeout_err", 32'(last_err[1]), 1);
        check("timeout_rdata", 32'(last_rdata[1]), 0);

        // Ready arrives in the same cycle as the timeout
        force_mask = 3'b001; f_we[0] = 1'b0; f_addr[0] = 16'h0021; force_lat = TO;
        run_quiet("ready_at_timeout", 60);
        check("coincide_err", 32'(last_err[0]), 0);
        check("coincide_rdata", 32'(last_rdata[0]), 32'(init_val(16'h21 & 63)));

        // Reset during an access
        force_mask = 3'b100; f_we[2] = 1'b0; f_addr[2] = 16'h0005; force_lat = TO + 1;
        repeat (5) begin @(negedge clk); step(); end
        check("pre_reset_mem_req", 32'(bus.mem_req), 1);
        saved_done = n_done;
        rst = 1'b1;
        #1;
        check("mid_rst_mem_req", 32'(bus.mem_req), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_gnt_id", 32'(bus.gnt_id), 0);
        exp_q.delete(); acc_q.delete(); lat_q.delete();
        pending = '0; bus.req = '0; idle = 1'b0; gap = 1'b0; starve = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle = 1'b1;
        force_mask = 3'b010; f_we[1] = 1'b0; f_addr[1] = 16'h0003; force_lat = 2;
        run_quiet("after_reset", 50);
        check("after_reset_one_done", n_done - saved_done, 1);

        // Randomised traffic
        force_lat = 0; rand_en = 1'b1;
        repeat (3000) begin @(negedge clk); step(); end
        rand_en = 1'b0;
        run_quiet("random", 200);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
